game_ctrl: RTL

Game-flow controller for the brick-breaker top level. It consumes the per-brick alive vector, the ball-lost event and the start button, and runs the serve/play/lose-life/win/game-over sequence. It drives the win/lose flags, lives, score, ball-park (serve) and motion-freeze controls. These feed the ball, paddle, life and overlay-colour logic. It sits directly upstream of the top-level win/lose colour selection.

---
 rtl/game_pkg.sv | 36 +++
 rtl/block_counter.sv | 26 ++
 rtl/game_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared state codes, default sizing constants and state
//                decode helpers for the brick-breaker game-flow logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    LOST_LIFE = 3'd3,
    WIN       = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam int DEF_NUM_BLOCKS   = 15;
  localparam int DEF_START_LIVES  = 3;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_PAUSE_FRAMES = 30;
  localparam int LIVES_W          = 2;

  // Ball is parked on the paddle while waiting to (re)launch.
  function automatic logic state_serves(input state_t s);
    return (s == IDLE) || (s == SERVE) || (s == LOST_LIFE);
  endfunction

  // Paddle and ball motion halted.
  function automatic logic state_freezes(input state_t s);
    return (s == IDLE) || (s == LOST_LIFE) || (s == WIN) || (s == GAME_OVER);
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_counter.sv
`default_nettype none
// ============================================================================
//  Module      : block_counter
//  Description : Combinational population count of the brick alive vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_counter
  import game_pkg::*;
#(
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
  input  logic [NUM_BLOCKS-1:0] alive,
  output logic [CNT_W-1:0]      count
);

  // Sum the alive flags into a count of bricks still standing.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      count = count + CNT_W'(alive[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl
//  Description : Brick-breaker game-flow controller. Sequences serve, play,
//                lost-life pause, win and game-over; tracks lives and score
//                and drives registered serve/freeze/win/lose controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_BLOCKS   = DEF_NUM_BLOCKS,
  parameter int START_LIVES  = DEF_START_LIVES,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_tick,
  input  logic                              start_btn,
  input  logic [NUM_BLOCKS-1:0]             alive,
  input  logic                              ball_lost,
  output logic [2:0]                        state,
  output logic                              serve,
  output logic                              freeze,
  output logic [LIVES_W-1:0]                lives,
  output logic [$clog2(NUM_BLOCKS+1)-1:0]   score,
  output logic                              win,
  output logic                              lose,
  output logic                              blocks_rst
);

  localparam int SCORE_W   = $clog2(NUM_BLOCKS + 1);
  localparam int FRAME_MAX = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int FCNT_W    = $clog2(FRAME_MAX + 1);

  localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  PAUSE_LAST = FCNT_W'(PAUSE_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_FULL = SCORE_W'(NUM_BLOCKS);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FCNT_W-1:0]    r_fcnt;
  logic                 r_start_prev;
  logic                 w_start_edge;
  logic                 w_new_game;
  logic [LIVES_W-1:0]   r_lives;
  logic [LIVES_W-1:0]   w_lives_nxt;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic [SCORE_W-1:0]   w_alive_cnt;
  logic                 r_serve;
  logic                 r_freeze;
  logic                 r_win;
  logic                 r_lose;
  logic                 r_blocks_rst;

  block_counter #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .CNT_W      (SCORE_W)
  ) u_block_counter (
    .alive (alive),
    .count (w_alive_cnt)
  );

  // start_prev resets high so a button held through reset never fires.
  assign w_start_edge = start_btn & ~r_start_prev;

  // Next-state, lives and score decisions; defaults hold current values.
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_new_game  = 1'b0;
    w_score_nxt = r_score;

    case (r_state)
      IDLE, WIN, GAME_OVER: begin
        if (w_start_edge) begin
          w_state_nxt = SERVE;
          w_new_game  = 1'b1;
        end
      end
      SERVE: begin
        if (w_start_edge || (frame_tick && (r_fcnt == SERVE_LAST))) begin
          w_state_nxt = PLAY;
        end
      end
      PLAY: begin
        // Clearing the last brick wins even if the ball drops that cycle.
        if (alive == '0) begin
          w_state_nxt = WIN;
        end else if (ball_lost) begin
          if (r_lives <= LIVES_W'(1)) begin
            w_lives_nxt = '0;
            w_state_nxt = GAME_OVER;
          end else begin
            w_lives_nxt = r_lives - LIVES_W'(1);
            w_state_nxt = LOST_LIFE;
          end
        end
      end
      LOST_LIFE: begin
        if (frame_tick && (r_fcnt == PAUSE_LAST)) begin
          w_state_nxt = SERVE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Score tracks destroyed bricks while a game is live, freezes at the end.
    case (r_state)
      SERVE, PLAY, LOST_LIFE: w_score_nxt = SCORE_FULL - w_alive_cnt;
      WIN, GAME_OVER:         w_score_nxt = r_score;
      default:                w_score_nxt = '0;
    endcase

    if (w_new_game) begin
      w_lives_nxt = LIVES_INIT;
      w_score_nxt = '0;
    end
  end

  // State, lives, score and decoded Moore outputs registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_lives      <= LIVES_INIT;
      r_score      <= '0;
      r_start_prev <= 1'b1;
      r_serve      <= 1'b1;
      r_freeze     <= 1'b1;
      r_win        <= 1'b0;
      r_lose       <= 1'b0;
      r_blocks_rst <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_start_prev <= start_btn;
      r_serve      <= state_serves(w_state_nxt);
      r_freeze     <= state_freezes(w_state_nxt);
      r_win        <= (w_state_nxt == WIN);
      r_lose       <= (w_state_nxt == GAME_OVER);
      r_blocks_rst <= w_new_game;
    end
  end

  // Frame counter restarts on every state entry and advances on frame ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fcnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_fcnt <= '0;
    end else if (frame_tick && (r_fcnt != '1)) begin
      r_fcnt <= r_fcnt + FCNT_W'(1);
    end
  end

  assign state      = r_state;
  assign serve      = r_serve;
  assign freeze     = r_freeze;
  assign lives      = r_lives;
  assign score      = r_score;
  assign win        = r_win;
  assign lose       = r_lose;
  assign blocks_rst = r_blocks_rst;

endmodule
`default_nettype wire
